// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester and its completers.
// Holds the FSM encoding, the default timeout and the completer register map.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   localparam int APB_TIMEOUT_DEFAULT = 16;

   localparam int REG_CTRL    = 0;
   localparam int REG_STATS   = 1;
   localparam int REG_TX_DATA = 2;
   localparam int REG_RX_DATA = 3;

endpackage

// File: rtl/apb_requester_if.sv
// Command/response handshake plus APB bus signals of the requester.
// The master modport is the requester view; the slave modport is the environment view.
interface apb_requester_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   logic [ADDR_W-1:0] PADDR;
   logic              PWRITE;
   logic [DATA_W-1:0] PWDATA;
   logic              PSEL;
   logic              PENABLE;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
             PADDR, PWRITE, PWDATA, PSEL, PENABLE
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
             PADDR, PWRITE, PWDATA, PSEL, PENABLE
   );

endinterface

// File: rtl/apb_requester.sv
// Single-outstanding APB requester: one command in, one SETUP/ACCESS transfer out,
// one-cycle response pulse back, with a bounded wait on PREADY.
module apb_requester
   import apb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = APB_TIMEOUT_DEFAULT
) (
   input  logic           PCLK,
   input  logic           PRESETn,
   apb_requester_if.master bus
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   apb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic              pwrite_q, pwrite_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [7:0]        wait_cnt_q, wait_cnt_d;
   logic [7:0]        wait_inc;

   // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d     = state_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      wait_cnt_d  = wait_cnt_q;
      psel_d      = 1'b0;
      penable_d   = 1'b0;
      rsp_valid_d = 1'b0;
      wait_inc    = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;

      // Bus strobes are computed for the next state so PSEL/PENABLE/rsp_valid come straight from flops.
      unique case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               state_d    = SETUP;
               paddr_d    = bus.cmd_addr;
               pwrite_d   = bus.cmd_write;
               pwdata_d   = bus.cmd_write ? bus.cmd_wdata : '0;
               wait_cnt_d = '0;
               psel_d     = 1'b1;
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            psel_d    = 1'b1;
            penable_d = 1'b1;
         end
         ACCESS: begin
            if (bus.PREADY) begin
               state_d     = RESP;
               rsp_err_d   = bus.PSLVERR;
               rsp_rdata_d = (!pwrite_q && !bus.PSLVERR) ? bus.PRDATA : '0;
               rsp_valid_d = 1'b1;
            end else begin
               wait_cnt_d = wait_inc;
               if (wait_inc == TIMEOUT_CNT) begin
                  state_d     = RESP;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
                  rsp_valid_d = 1'b1;
               end else begin
                  psel_d    = 1'b1;
                  penable_d = 1'b1;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q     <= IDLE;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.PADDR     = paddr_q;
   assign bus.PWRITE    = pwrite_q;
   assign bus.PWDATA    = pwdata_q;
   assign bus.PSEL      = psel_q;
   assign bus.PENABLE   = penable_q;

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester with a small configurable APB completer model.
// Outputs are sampled on the falling edge; commands are driven on the falling edge.
module tb_apb_requester;
   import apb_pkg::*;

   logic PCLK = 1'b0;
   logic PRESETn;
   int   checks = 0;
   int   errors = 0;

   apb_requester_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .bus     (bus)
   );

   always #5 PCLK = ~PCLK;

   // Completer model: answers after comp_waits wait states, or never when comp_hang is set.
   logic        comp_hang    = 1'b0;
   logic        comp_err     = 1'b0;
   logic        pready_force = 1'b0;
   int          comp_waits   = 0;
   logic [31:0] comp_rdata   = '0;
   int          acc_cnt      = 0;
   int          comp_count   = 0;

   always @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) acc_cnt <= 0;
      else if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
   end

   always @(posedge PCLK) begin
      if (PRESETn && bus.PSEL && bus.PENABLE && bus.PREADY) comp_count <= comp_count + 1;
   end

   assign bus.PREADY  = pready_force ||
                        (bus.PSEL && bus.PENABLE && !comp_hang && (acc_cnt >= comp_waits));
   assign bus.PRDATA  = comp_rdata;
   assign bus.PSLVERR = comp_err;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Issue one command from an IDLE falling edge; return response latency and ACCESS cycle count.
   task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int max_cyc, output int lat, output int n_access);
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      bus.cmd_valid = 1'b1;
      lat      = -1;
      n_access = 0;
      for (int k = 1; k <= max_cyc && lat < 0; k++) begin
         @(negedge PCLK);
         bus.cmd_valid = 1'b0;
         if (bus.PSEL && bus.PENABLE) n_access++;
         if (bus.rsp_valid) lat = k;
      end
      if (lat < 0) begin
         checks++;
         errors++;
         $display("FAIL run_cmd_timeout: no rsp_valid within %0d cycles", max_cyc);
      end
      @(negedge PCLK);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge PCLK);
      checks++;
      if ({bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.rsp_err, bus.PWRITE} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b exp 00000",
                  {bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.rsp_err, bus.PWRITE});
      end
      checks++;
      if ({bus.PADDR, bus.PWDATA, bus.rsp_rdata} !== 96'h0) begin
         errors++;
         $display("FAIL reset_data: got %h %h %h exp 0", bus.PADDR, bus.PWDATA, bus.rsp_rdata);
      end
      PRESETn = 1'b1;
      @(negedge PCLK);
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b exp 1", bus.cmd_ready);
      end
   endtask

   task automatic test_write();
      comp_waits    = 0;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = REG_CTRL;
      bus.cmd_wdata = 32'h0000_0003;
      bus.cmd_valid = 1'b1;
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL wr_ready: got %b exp 1", bus.cmd_ready);
      end
      @(negedge PCLK);
      bus.cmd_valid = 1'b0;
      checks++;
      if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid} !== 4'b1010) begin
         errors++;
         $display("FAIL wr_setup: got %b exp 1010", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid});
      end
      checks++;
      if (bus.PWDATA !== 32'h3 || bus.PADDR !== 32'h0) begin
         errors++;
         $display("FAIL wr_setup_data: got %h@%h exp 00000003@00000000", bus.PWDATA, bus.PADDR);
      end
      @(negedge PCLK);
      checks++;
      if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b110 || bus.PWDATA !== 32'h3) begin
         errors++;
         $display("FAIL wr_access: got %b %h exp 110 00000003",
                  {bus.PSEL, bus.PENABLE, bus.rsp_valid}, bus.PWDATA);
      end
      @(negedge PCLK);
      checks++;
      if ({bus.rsp_valid, bus.rsp_err, bus.PSEL, bus.PENABLE} !== 4'b1000) begin
         errors++;
         $display("FAIL wr_resp: got %b exp 1000", {bus.rsp_valid, bus.rsp_err, bus.PSEL, bus.PENABLE});
      end
      @(negedge PCLK);
      checks++;
      if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01 || bus.PWDATA !== 32'h3) begin
         errors++;
         $display("FAIL wr_idle: got %b %h exp 01 00000003", {bus.rsp_valid, bus.cmd_ready}, bus.PWDATA);
      end
   endtask

   task automatic test_read_wait();
      int lat, nacc;
      comp_waits = 1;
      comp_rdata = 32'h0000_00A5;
      run_cmd(1'b0, REG_RX_DATA, 32'hFFFF_FFFF, 10, lat, nacc);
      checks++;
      if (lat !== 4 || nacc !== 2) begin
         errors++;
         $display("FAIL rd_wait_lat: got lat %0d access %0d exp 4 2", lat, nacc);
      end
      checks++;
      if (bus.rsp_rdata !== 32'h0000_00A5 || bus.rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL rd_wait_data: got %h err %b exp 000000a5 0", bus.rsp_rdata, bus.rsp_err);
      end
      checks++;
      if (bus.PWDATA !== 32'h0 || bus.PADDR !== 32'h3 || bus.PWRITE !== 1'b0) begin
         errors++;
         $display("FAIL rd_wait_bus: got %h@%h w%b exp 00000000@00000003 w0",
                  bus.PWDATA, bus.PADDR, bus.PWRITE);
      end
      comp_waits = 0;
   endtask

   task automatic test_slverr();
      int lat, nacc;
      comp_err   = 1'b1;
      comp_rdata = 32'hDEAD_BEEF;
      run_cmd(1'b0, REG_STATS, 32'h0, 10, lat, nacc);
      checks++;
      if (lat !== 3) begin
         errors++;
         $display("FAIL slverr_lat: got %0d exp 3", lat);
      end
      checks++;
      if (bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0 || bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL slverr_rsp: got err %b data %h valid %b exp 1 00000000 0",
                  bus.rsp_err, bus.rsp_rdata, bus.rsp_valid);
      end
      comp_err = 1'b0;
   endtask

   task automatic test_read_ok();
      int lat, nacc;
      comp_rdata = 32'h1234_5678;
      run_cmd(1'b0, REG_STATS, 32'h0, 10, lat, nacc);
      checks++;
      if (lat !== 3 || bus.rsp_rdata !== 32'h1234_5678 || bus.rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL rd_ok: got lat %0d data %h err %b exp 3 12345678 0", lat, bus.rsp_rdata, bus.rsp_err);
      end
   endtask

   task automatic test_timeout();
      int lat, nacc;
      comp_hang = 1'b1;
      run_cmd(1'b0, REG_TX_DATA, 32'h0, 40, lat, nacc);
      checks++;
      if (nacc !== 16 || lat !== 18) begin
         errors++;
         $display("FAIL timeout_len: got access %0d lat %0d exp 16 18", nacc, lat);
      end
      checks++;
      if (bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
         errors++;
         $display("FAIL timeout_rsp: got err %b data %h exp 1 00000000", bus.rsp_err, bus.rsp_rdata);
      end
      comp_hang = 1'b0;
   endtask

   task automatic test_pready_ignored();
      int lat, nacc, n_rsp;
      pready_force = 1'b1;
      n_rsp = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge PCLK);
         if (bus.rsp_valid || bus.PSEL) n_rsp++;
      end
      checks++;
      if (n_rsp !== 0) begin
         errors++;
         $display("FAIL pready_idle: got %0d active cycles exp 0", n_rsp);
      end
      run_cmd(1'b1, REG_TX_DATA, 32'h55, 10, lat, nacc);
      checks++;
      if (lat !== 3 || nacc !== 1) begin
         errors++;
         $display("FAIL pready_setup: got lat %0d access %0d exp 3 1", lat, nacc);
      end
      pready_force = 1'b0;
   endtask

   task automatic test_back_to_back();
      int acc_at[3];
      int n_acc, n_rsp, psel_in_resp, start_cc;
      logic drop_next;
      n_acc = 0; n_rsp = 0; psel_in_resp = 0; drop_next = 1'b0;
      acc_at = '{default: 0};
      start_cc      = comp_count;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = REG_TX_DATA;
      bus.cmd_wdata = 32'h77;
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < 14; i++) begin
         if (bus.cmd_valid && bus.cmd_ready) begin
            if (n_acc < 3) acc_at[n_acc] = i;
            n_acc++;
            if (n_acc == 3) drop_next = 1'b1;
         end
         if (bus.rsp_valid) n_rsp++;
         if (bus.rsp_valid && bus.PSEL) psel_in_resp++;
         @(negedge PCLK);
         if (drop_next) begin
            bus.cmd_valid = 1'b0;
            drop_next     = 1'b0;
         end
      end
      checks++;
      if (n_acc !== 3 || acc_at[1] - acc_at[0] !== 4 || acc_at[2] - acc_at[1] !== 4) begin
         errors++;
         $display("FAIL b2b_spacing: got %0d accepts at %0d %0d %0d exp 3 at 0 4 8",
                  n_acc, acc_at[0], acc_at[1], acc_at[2]);
      end
      checks++;
      if (n_rsp !== 3 || psel_in_resp !== 0 || comp_count - start_cc !== 3) begin
         errors++;
         $display("FAIL b2b_resp: got rsp %0d psel_in_resp %0d completions %0d exp 3 0 3",
                  n_rsp, psel_in_resp, comp_count - start_cc);
      end
   endtask

   task automatic test_reset_mid();
      int n_rsp, lat, nacc;
      comp_hang     = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = REG_RX_DATA;
      bus.cmd_valid = 1'b1;
      @(negedge PCLK);
      bus.cmd_valid = 1'b0;
      repeat (2) @(negedge PCLK);
      checks++;
      if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin
         errors++;
         $display("FAIL rst_mid_pre: got %b exp 11", {bus.PSEL, bus.PENABLE});
      end
      #1 PRESETn = 1'b0;
      #1;
      checks++;
      if ({bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready} !== 4'b0001 || bus.PADDR !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_now: got %b paddr %h exp 0001 00000000",
                  {bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready}, bus.PADDR);
      end
      comp_hang = 1'b0;
      @(negedge PCLK);
      PRESETn = 1'b1;
      @(negedge PCLK);
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_ready: got %b exp 1", bus.cmd_ready);
      end
      n_rsp = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.rsp_valid) n_rsp++;
         @(negedge PCLK);
      end
      checks++;
      if (n_rsp !== 0) begin
         errors++;
         $display("FAIL rst_mid_norsp: got %0d pulses exp 0", n_rsp);
      end
      run_cmd(1'b1, REG_CTRL, 32'h9, 10, lat, nacc);
      checks++;
      if (lat !== 3 || bus.rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_after: got lat %0d err %b exp 3 0", lat, bus.rsp_err);
      end
   endtask

   initial begin
      PRESETn       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      test_reset();
      test_write();
      test_read_wait();
      test_slverr();
      test_read_ok();
      test_timeout();
      test_pready_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
